// File: rtl/s_machine_pkg.sv
// Shared definitions for the S-Machine executor: opcodes, FSM states, flag bits.
package s_machine_pkg;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_ILL3 = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_EXCH = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_SET  = 4'hD;
  localparam logic [3:0] OP_CLR  = 4'hE;
  localparam logic [3:0] OP_ILLF = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM
  } state_e;

  // Bit positions inside the {Z,N,C} flag vector
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL3) || (op == OP_ILLF);
  endfunction

  // LD with inst[10]=0 and every ST go through the memory handshake
  function automatic logic is_mem_op(input logic [3:0] op, input logic imm_sel);
    return (op == OP_ST) || ((op == OP_LD) && !imm_sel);
  endfunction

endpackage

// File: rtl/s_machine_alu.sv
// Combinational datapath: next A/B and next {Z,N,C} for all non-memory opcodes.
module s_machine_alu
  import s_machine_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [3:0]        ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        flags,
  output logic [DATA_W-1:0] a_nxt,
  output logic [DATA_W-1:0] b_nxt,
  output logic [2:0]        flags_nxt
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] sel;
  logic              upd_zn;

  // Decode opcode into register results and flag updates
  always_comb begin
    a_nxt     = a;
    b_nxt     = b;
    flags_nxt = flags;
    sum       = '0;
    res       = '0;
    upd_zn    = 1'b0;
    sel       = ctl[3] ? b : a;

    unique case (op)
      OP_LD: begin
        if (ctl[2]) begin
          res = ctl[1] ? (imm << (DATA_W - 8)) : imm;
          if (ctl[3]) b_nxt = res;
          else        a_nxt = res;
        end
      end
      OP_INC: begin
        sum = {1'b0, sel} + {1'b0, imm};
        res = sum[DATA_W-1:0];
        if (ctl[3]) b_nxt = res;
        else        a_nxt = res;
        flags_nxt[FLAG_C] = sum[DATA_W];
        upd_zn = 1'b1;
      end
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        res   = sum[DATA_W-1:0];
        a_nxt = res;
        flags_nxt[FLAG_C] = sum[DATA_W];
        upd_zn = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // Extra top bit of the widened difference is the unsigned borrow
        sum = {1'b0, a} - {1'b0, b};
        res = sum[DATA_W-1:0];
        if (op == OP_SUB) a_nxt = res;
        flags_nxt[FLAG_C] = sum[DATA_W];
        upd_zn = 1'b1;
      end
      OP_OR:  begin res = a | b; a_nxt = res; upd_zn = 1'b1; end
      OP_AND: begin res = a & b; a_nxt = res; upd_zn = 1'b1; end
      OP_XOR: begin res = a ^ b; a_nxt = res; upd_zn = 1'b1; end
      OP_SHR: begin
        res   = a >> 1;
        a_nxt = res;
        flags_nxt[FLAG_C] = a[0];
        upd_zn = 1'b1;
      end
      OP_MOV:  b_nxt = a;
      OP_EXCH: begin a_nxt = b; b_nxt = a; end
      OP_SET:  flags_nxt = flags | ctl[2:0];
      OP_CLR:  flags_nxt = flags & ~ctl[2:0];
      default: ;
    endcase

    if (upd_zn) begin
      flags_nxt[FLAG_Z] = (res == '0);
      flags_nxt[FLAG_N] = res[DATA_W-1];
    end
  end

endmodule

// File: rtl/s_machine_exec_unit.sv
// S-Machine executor top: accept/exec FSM, A/B/pc/flag registers, memory handshake.
module s_machine_exec_unit
  import s_machine_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [2:0]        flags
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       inst_q, inst_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        flags_q, flags_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              done_q, done_d, err_q, err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TW-1:0]     cnt_q, cnt_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [2:0]        alu_flags;

  assign op  = inst_q[15:12];
  assign imm = DATA_W'(inst_q[7:0]);

  s_machine_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op        (op),
    .ctl       (inst_q[11:8]),
    .a         (a_q),
    .b         (b_q),
    .imm       (imm),
    .flags     (flags_q),
    .a_nxt     (alu_a),
    .b_nxt     (alu_b),
    .flags_nxt (alu_flags)
  );

  // Next-state logic for the FSM, architectural registers and memory port
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    pc_d        = pc_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op(op, inst_q[10])) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (op == OP_ST);
          mem_addr_d  = ADDR_W'(inst_q[7:0]);
          mem_wdata_d = inst_q[11] ? b_q : a_q;
          cnt_d       = '0;
          state_d     = S_MEM;
        end else begin
          if (is_illegal(op)) begin
            err_d = 1'b1;
          end else begin
            a_d     = alu_a;
            b_d     = alu_b;
            flags_d = alu_flags;
          end
          done_d  = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_IDLE;
        end
      end
      S_MEM: begin
        // An ack on the final allowed cycle still completes normally
        if (mem_ack) begin
          if (!mem_we_q) begin
            if (inst_q[11]) b_d = mem_rdata;
            else            a_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          pc_d      = pc_q + PC_W'(1);
          state_d   = S_IDLE;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          pc_d      = pc_q + PC_W'(1);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      pc_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      flags_q     <= flags_d;
      pc_q        <= pc_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign inst_ready = (state_q == S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pc         = pc_q;
  assign reg_a      = a_q;
  assign reg_b      = b_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_s_machine_exec_unit.sv
// Randomised self-checking bench for s_machine_exec_unit with a behavioural model.
module tb_s_machine_exec_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        done, err;
  logic [7:0]  pc;
  logic [15:0] reg_a, reg_b;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  logic [15:0] exp_a, exp_b;
  logic        fz, fn, fc;
  logic [7:0]  exp_pc;
  logic        exp_err;
  logic [15:0] mem_model [256];

  always #5 clk = ~clk;

  s_machine_exec_unit #(
    .DATA_W      (16),
    .ADDR_W      (8),
    .PC_W        (8),
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .done       (done),
    .err        (err),
    .pc         (pc),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .flags      (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    exp_a = 16'h0; exp_b = 16'h0;
    fz = 1'b0; fn = 1'b0; fc = 1'b0;
    exp_pc = 8'h0; exp_err = 1'b0;
  endfunction

  function automatic void put_sel(input logic to_b, input logic [15:0] v);
    if (to_b) exp_b = v;
    else      exp_a = v;
  endfunction

  function automatic void set_zn(input logic [15:0] r);
    fz = (r == 16'h0);
    fn = (r >= 16'h8000);
  endfunction

  // Register-level meaning of each non-memory opcode
  function automatic void model_exec(input logic [15:0] ins);
    logic [15:0] imm, s, r;
    int unsigned t;
    imm = {8'h00, ins[7:0]};
    s = ins[11] ? exp_b : exp_a;
    exp_err = 1'b0;
    case (ins[15:12])
      4'h0: put_sel(ins[11], ins[9] ? 16'(imm * 256) : imm);
      4'h2: begin
        t = s + imm;
        r = t[15:0];
        put_sel(ins[11], r); set_zn(r); fc = (t > 32'd65535);
      end
      4'h4: begin
        t = exp_a + exp_b;
        exp_a = t[15:0]; set_zn(exp_a); fc = (t > 32'd65535);
      end
      4'h5: begin
        fc = (exp_a < exp_b);
        exp_a = exp_a - exp_b; set_zn(exp_a);
      end
      4'h6: begin exp_a = exp_a | exp_b; set_zn(exp_a); end
      4'h7: begin exp_a = exp_a & exp_b; set_zn(exp_a); end
      4'h8: begin exp_a = exp_a ^ exp_b; set_zn(exp_a); end
      4'h9: begin fc = exp_a[0]; exp_a = exp_a / 2; set_zn(exp_a); end
      4'hA: exp_b = exp_a;
      4'hB: begin r = exp_a; exp_a = exp_b; exp_b = r; end
      4'hC: begin fc = (exp_a < exp_b); r = exp_a - exp_b; set_zn(r); end
      4'hD: begin fz = fz | ins[10]; fn = fn | ins[9]; fc = fc | ins[8]; end
      4'hE: begin fz = fz & ~ins[10]; fn = fn & ~ins[9]; fc = fc & ~ins[8]; end
      default: exp_err = 1'b1;
    endcase
    exp_pc = exp_pc + 8'd1;
  endfunction

  task automatic check_retire(input string tag);
    check({tag, "_done"},  32'(done),       32'd1);
    check({tag, "_err"},   32'(err),        32'(exp_err));
    check({tag, "_a"},     32'(reg_a),      32'(exp_a));
    check({tag, "_b"},     32'(reg_b),      32'(exp_b));
    check({tag, "_flags"}, 32'(flags),      32'({fz, fn, fc}));
    check({tag, "_pc"},    32'(pc),         32'(exp_pc));
    check({tag, "_ready"}, 32'(inst_ready), 32'd1);
  endtask

  // Issue one instruction; waits = ack after that many wait cycles, <0 = never ack
  task automatic exec(input logic [15:0] ins, input int waits);
    logic        is_mem, is_st, acked;
    logic [7:0]  addr;
    logic [15:0] sel;
    int          reqc;
    is_st  = (ins[15:12] == 4'h1);
    is_mem = is_st || (ins[15:12] == 4'h0 && !ins[10]);
    addr   = ins[7:0];
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("ready_idle", 32'(inst_ready), 32'd1);
    inst = ins; inst_valid = 1'b1;
    @(negedge clk);
    check("ready_busy", 32'(inst_ready), 32'd0);
    check("done_early", 32'(done), 32'd0);
    check("req_early", 32'(mem_req), 32'd0);
    // Busy-time noise: stray instructions and acks that must be ignored
    inst = 16'($urandom); inst_valid = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    if (!is_mem) begin
      model_exec(ins);
      @(negedge clk);
      inst_valid = 1'b0; mem_ack = 1'b0;
      check_retire("alu");
    end else begin
      sel = ins[11] ? exp_b : exp_a;
      reqc = 0; acked = 1'b0;
      @(negedge clk);
      for (int c = 0; c < TIMEOUT; c++) begin
        check("req_high", 32'(mem_req), 32'd1);
        check("req_we", 32'(mem_we), 32'(is_st));
        check("req_addr", 32'(mem_addr), 32'(addr));
        if (is_st) check("req_wdata", 32'(mem_wdata), 32'(sel));
        check("req_nodone", 32'(done), 32'd0);
        reqc++;
        if (c == waits) begin
          mem_ack = 1'b1; mem_rdata = mem_model[addr]; acked = 1'b1;
        end else begin
          mem_ack = 1'b0; mem_rdata = 16'($urandom);
        end
        @(negedge clk);
        if (acked) break;
      end
      inst_valid = 1'b0; mem_ack = 1'b0;
      check("req_drop", 32'(mem_req), 32'd0);
      if (acked) begin
        exp_err = 1'b0;
        if (is_st) mem_model[addr] = sel;
        else       put_sel(ins[11], mem_model[addr]);
        check("req_cycles", 32'(reqc), 32'(waits + 1));
      end else begin
        exp_err = 1'b1;
        check("timeout_cycles", 32'(reqc), 32'(TIMEOUT));
      end
      exp_pc = exp_pc + 8'd1;
      check_retire(is_st ? "st" : "ld");
    end
  endtask

  function automatic logic [15:0] rand_alu_inst();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[15:12] == 4'h0) r[10] = 1'b1;
    if (r[15:12] == 4'h1) r[15:12] = 4'h2;
    return r;
  endfunction

  initial begin
    logic [15:0] ri;
    int          w;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    rst = 1'b1; inst = 16'h0; inst_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(inst_ready), 32'd1);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_pc",    32'(pc), 32'd0);
    check("rst_a",     32'(reg_a), 32'd0);
    check("rst_b",     32'(reg_b), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    // Reset while a store is waiting for ack
    exec(16'h0412, 0);
    @(negedge clk);
    inst = 16'h1020; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    check("midst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req",  32'(mem_req), 32'd0);
    check("midrst_pc",   32'(pc), 32'd0);
    check("midrst_a",    32'(reg_a), 32'd0);
    check("midrst_b",    32'(reg_b), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    model_reset();

    // Immediate loads, low and high byte
    exec(16'h0412, 0);
    check("ldimm_a", 32'(reg_a), 32'h0012);
    exec(16'h0E34, 0);
    check("ldimm_b", 32'(reg_b), 32'h3400);

    // ADD with carry out to zero, then SUB with borrow
    exec(16'h06FF, 0);
    exec(16'h22FF, 0);
    exec(16'h0C01, 0);
    exec(16'h4000, 0);
    check("add_a", 32'(reg_a), 32'h0000);
    check("add_flags", 32'(flags), 32'b101);
    exec(16'h0401, 0);
    exec(16'h0C02, 0);
    exec(16'h5000, 0);
    check("sub_a", 32'(reg_a), 32'hFFFF);
    check("sub_flags", 32'(flags), 32'b011);

    // Store with three wait states, read back, then a load that times out
    exec(16'h1020, 3);
    exec(16'h0820, 1);
    check("ldback_b", 32'(reg_b), 32'hFFFF);
    exec(16'h0033, -1);

    // Randomised mix including memory ops, timeouts and illegal opcodes
    for (int n = 0; n < 150; n++) begin
      ri = 16'($urandom);
      w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      exec(ri, w);
    end

    // Drive pc to its top value and retire an illegal opcode to wrap it
    while (exp_pc != 8'hFF) exec(rand_alu_inst(), 0);
    check("pc_top", 32'(pc), 32'h00FF);
    exec(16'hF000, 0);
    check("wrap_pc", 32'(pc), 32'h0000);
    check("wrap_err", 32'(err), 32'd1);
    exec(16'h3123, 0);
    @(negedge clk);
    check("final_done_low", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
